gray_gauss_window: RTL and testbench
====================================

Name: gray_gauss_window

Overview:
- Streaming front end of the edge-detection pipeline.
- Takes one RGB444 pixel per clock in raster order and converts it to a 4-bit luminance.
- Builds a 3x3 neighbourhood from two internal line memories and applies a 3x3 Gaussian blur.
- Emits the blurred gray pixel, the unblurred centre gray pixel, and centre coordinates to the downstream median/Sobel stages.

Parameters:
- IMG_WIDTH, 640, pixels per line; sets the line memory depth.
- IMG_HEIGHT, 480, lines per frame; used only for the coordinate range check.
- COORD_W, 10, width of x/y coordinates.

Ports:
- clk  in  1  pixel clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- x_pixel  in  COORD_W  column of the current input pixel.
- y_pixel  in  COORD_W  row of the current input pixel.
- data  in  12  input pixel {R[3:0],G[3:0],B[3:0]}.
- gauss_out  out  12  blurred gray, replicated {g,g,g}.
- gray_out  out  12  centre gray before blur, replicated {g,g,g}.
- out_x  out  COORD_W  column of the window centre.
- out_y  out  COORD_W  row of the window centre.
- out_valid  out  1  high when the window is fully inside written image data.

Behaviour:
- Input acceptance: a pixel is accepted on a rising edge when x_pixel<IMG_WIDTH and y_pixel<IMG_HEIGHT.
  - Out-of-range coordinates: no memory write, no window shift, out_valid<=0.
- Grayscale per pixel:
  - g = (77*R + 150*G + 29*B) >> 8, using a 16-bit intermediate; result range 0..15.
  - Conversion happens combinationally on the input, before storage, so the line memories hold 4-bit gray.
- Line memories: two IMG_WIDTH x 4 memories.
  - lineA holds row y-1 and lineB holds row y-2.
  - On an accepted pixel at x: lineB[x]<=lineA[x] and lineA[x]<=g (read-before-write, same edge).
  - Memories are not cleared by reset.
- Window: 3x3 registers W[r][c], row 0 = oldest, column 2 = newest.
  - Each accepted edge shifts left: W[r][0]<=W[r][1], W[r][1]<=W[r][2].
  - New column: W[0][2]<=lineB[x], W[1][2]<=lineA[x], W[2][2]<=g.
  - After the edge for input (x,y), the centre W[1][1] = gray(x-1, y-1).
- Gaussian, combinational on the window:
  - Kernel [1 2 1; 2 4 2; 1 2 1].
  - sum = W00+2W01+W02+2W10+4W11+2W12+W20+2W21+W22, 8 bits, max 240.
  - gb = sum>>4 (truncate, no rounding).
- Output register, updated on the edge after the window edge:
  - gauss_out<={gb,gb,gb}; gray_out<={W11,W11,W11}.
  - out_x<=x-1 and out_y<=y-1 of the input that loaded the window.
  - Total latency from input edge to output: 2 clocks.
- out_valid: registered; high iff the window-loading pixel had x>=2 and y>=2.
  - Border centres (row 0, column 0, last row, last column) never assert out_valid; their data is don't-care.
- Line wrap: no flush; window columns from the previous line's tail are invalidated by the x>=2 rule.
- Reset, asynchronous:
  - All window registers, gauss_out, gray_out, out_x, out_y and out_valid go to 0 immediately.
  - After reset release, out_valid stays low until two new full lines plus 3 pixels have been accepted (y>=2 re-qualification uses incoming coordinates; memories may contain stale data only on rows already gated).
- Simultaneous reset and pixel: reset wins.

Decomposition:
- Package gray_gauss_pkg:
  - rgb444_t struct {r,g,b} of 4 bits each.
  - Constants GRAY_WR=77, GRAY_WG=150, GRAY_WB=29.
  - Function rgb444_to_gray4.
  - Gaussian kernel weights and shift (4).
- One sub-module line_window_3x3: line memories plus window registers, parameterised by IMG_WIDTH and pixel width, reusable by the median and Sobel stages.
- Grayscale and Gaussian arithmetic stay in the top module.

Test Plan:
- Uniform frame data=0x888 -> once out_valid, gauss_out=0x888 and gray_out=0x888 every valid cycle.
- Colour weights via a uniform frame of 0xF00 / 0x0F0 / 0x00F / 0xFFF -> gray_out 0x444 / 0x888 / 0x111 / 0xFFF.
- Impulse: black 640x480 frame, single 0xFFF pixel at (100,50):
  - centre (100,50): gauss_out=0x333.
  - (101,50) and (100,51): 0x111.
  - diagonal (101,51): 0x000.
  - all outputs arrive 2 clocks after the loading pixel.
- Latency/coordinates: feed pixel (5,3) -> two edges later out_x=4, out_y=2, out_valid=1.
  - For inputs with x<2 or y<2, out_valid=0.
- Reset mid-frame at line 200: outputs 0 asynchronously.
  - After release, restart at y=0: out_valid first rises 2 clocks after input (2,2).
- Out-of-range input x_pixel=700 -> window unchanged, no memory write, out_valid=0 next edge.

Source files
------------

// File: rtl/gray_gauss_pkg.sv
// -----------------------------------------------------------------------------
// gray_gauss_pkg
// Shared types and arithmetic for the gray/Gaussian front end.
//   rgb444_t         : packed {r,g,b} pixel, 4 bits per channel
//   GRAY_W*          : luminance weights (sum 256, so >>8 normalises)
//   rgb444_to_gray4  : RGB444 -> 4-bit luminance
//   GAUSS_K/SHIFT    : 3x3 binomial kernel (sum 16) and its normalising shift
// -----------------------------------------------------------------------------
package gray_gauss_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int unsigned GRAY_WR = 77;
    localparam int unsigned GRAY_WG = 150;
    localparam int unsigned GRAY_WB = 29;

    // Row-major kernel, entry (0,0) in the top byte.
    localparam logic [71:0] GAUSS_K = {8'd1, 8'd2, 8'd1,
                                       8'd2, 8'd4, 8'd2,
                                       8'd1, 8'd2, 8'd1};
    localparam int GAUSS_SHIFT = 4;

    // Weights sum to 256 and channels are at most 15, so the 16-bit
    // intermediate never exceeds 3840 and the shifted result fits 4 bits.
    function automatic logic [3:0] rgb444_to_gray4(input rgb444_t p);
        logic [15:0] acc;
        acc = 16'(GRAY_WR) * 16'(p.r)
            + 16'(GRAY_WG) * 16'(p.g)
            + 16'(GRAY_WB) * 16'(p.b);
        return 4'(acc >> 8);
    endfunction

    function automatic logic [7:0] gauss_weight(input int r, input int c);
        return 8'(GAUSS_K >> (8 * (8 - (3 * r + c))));
    endfunction

endpackage

// File: rtl/line_window_3x3.sv
// -----------------------------------------------------------------------------
// line_window_3x3
// Two line memories plus a 3x3 sliding window over a raster pixel stream.
//   clk      : pixel clock
//   reset    : asynchronous active-high; clears the window (not the memories)
//   shift_en : accept the pixel on this edge (write memories, shift window)
//   col      : column of the incoming pixel
//   pix      : incoming pixel
//   win      : window, win[row][col]; row 0 oldest line, col 2 newest pixel
// -----------------------------------------------------------------------------
module line_window_3x3 #(
    parameter int IMG_WIDTH = 640,
    parameter int PIX_W     = 4,
    parameter int ADDR_W    = $clog2(IMG_WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [ADDR_W-1:0] col,
    input  logic [PIX_W-1:0]  pix,
    output logic [PIX_W-1:0]  win [3][3]
);

    logic [PIX_W-1:0] line_a [IMG_WIDTH];   // row y-1
    logic [PIX_W-1:0] line_b [IMG_WIDTH];   // row y-2

    // NOTE: memories carry no reset so they map onto RAM; stale contents are
    // harmless because out_valid is gated by incoming coordinates.
    // NOTE: non-blocking assignments make line_b pick up the old line_a word,
    // giving read-before-write on the same edge.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            line_b[col] <= line_a[col];
            line_a[col] <= pix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (shift_en) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= line_b[col];
            win[1][2] <= line_a[col];
            win[2][2] <= pix;
        end
    end

endmodule

// File: rtl/gray_gauss_window.sv
// -----------------------------------------------------------------------------
// gray_gauss_window
// RGB444 raster stream -> 4-bit gray -> 3x3 Gaussian blur, two clocks latency.
//   clk       : pixel clock
//   reset     : asynchronous active-high reset
//   x_pixel   : column of the input pixel
//   y_pixel   : row of the input pixel
//   data      : input pixel {R,G,B}
//   gauss_out : blurred gray, {g,g,g}
//   gray_out  : unblurred window-centre gray, {g,g,g}
//   out_x     : column of the window centre
//   out_y     : row of the window centre
//   out_valid : window lies entirely inside freshly written image data
// -----------------------------------------------------------------------------
module gray_gauss_window
    import gray_gauss_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COORD_W    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x_pixel,
    input  logic [COORD_W-1:0] y_pixel,
    input  logic [11:0]        data,
    output logic [11:0]        gauss_out,
    output logic [11:0]        gray_out,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_valid
);

    localparam int ADDR_W = $clog2(IMG_WIDTH);
    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(IMG_WIDTH);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(IMG_HEIGHT);

    logic       in_range;
    logic       accept;
    logic [3:0] gray_in;
    logic [3:0] win [3][3];
    logic [7:0] gauss_sum;
    logic [3:0] gauss_gray;

    // Window-stage bookkeeping, aligned with the window registers.
    logic               win_valid;
    logic [COORD_W-1:0] win_x;
    logic [COORD_W-1:0] win_y;

    assign in_range = (x_pixel < X_LIM) && (y_pixel < Y_LIM);
    // Reset also blocks memory writes so a pixel coinciding with reset is lost.
    assign accept   = in_range && !reset;
    assign gray_in  = rgb444_to_gray4(rgb444_t'(data));

    line_window_3x3 #(
        .IMG_WIDTH (IMG_WIDTH),
        .PIX_W     (4),
        .ADDR_W    (ADDR_W)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .shift_en (accept),
        .col      (x_pixel[ADDR_W-1:0]),
        .pix      (gray_in),
        .win      (win)
    );

    // NOTE: the sum is given a value before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        gauss_sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                gauss_sum = gauss_sum + gauss_weight(r, c) * 8'(win[r][c]);
            end
        end
    end

    // Maximum sum is 240, so truncating the shift keeps 4 bits.
    assign gauss_gray = 4'(gauss_sum >> GAUSS_SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
        end else if (in_range) begin
            // Centre lags the input by one row and one column; the x>=2 rule
            // also discards columns left over from the previous line's tail.
            win_valid <= (x_pixel >= COORD_W'(2)) && (y_pixel >= COORD_W'(2));
            win_x     <= x_pixel - COORD_W'(1);
            win_y     <= y_pixel - COORD_W'(1);
        end else begin
            win_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gauss_out <= '0;
            gray_out  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_valid <= 1'b0;
        end else begin
            gauss_out <= {3{gauss_gray}};
            gray_out  <= {3{win[1][1]}};
            out_x     <= win_x;
            out_y     <= win_y;
            out_valid <= win_valid;
        end
    end

endmodule

// File: tb/tb_gray_gauss_window.sv
// -----------------------------------------------------------------------------
// tb_gray_gauss_window
// Directed bench for gray_gauss_window. Inputs change 1 ns after a rising edge
// and outputs are sampled there too, so after feeding pixel N the outputs
// belong to pixel N-1 (two edges after it was presented).
// -----------------------------------------------------------------------------
module tb_gray_gauss_window;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] x_pixel;
    logic [CW-1:0] y_pixel;
    logic [11:0]   data;
    logic [11:0]   gauss_out;
    logic [11:0]   gray_out;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic          out_valid;

    int errors = 0;
    int checks = 0;

    gray_gauss_window #(
        .IMG_WIDTH  (640),
        .IMG_HEIGHT (480),
        .COORD_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x_pixel   (x_pixel),
        .y_pixel   (y_pixel),
        .data      (data),
        .gauss_out (gauss_out),
        .gray_out  (gray_out),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic feed(input int x, input int y, input logic [11:0] d);
        x_pixel = CW'(x);
        y_pixel = CW'(y);
        data    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        feed(1023, 1023, 12'h000);
    endtask

    // Streams a uniform rectangle and checks each pixel's output one feed later.
    task automatic stream_rect(input string name, input int x0, input int x1,
                               input int y0, input int y1,
                               input logic [11:0] d, input logic [11:0] exp_g);
        int w, total, px, py;
        logic exp_v;
        w     = x1 - x0 + 1;
        total = w * (y1 - y0 + 1);
        for (int i = 0; i <= total; i++) begin
            if (i < total) feed(x0 + i % w, y0 + i / w, d);
            else idle();
            if (i > 0) begin
                px    = x0 + (i - 1) % w;
                py    = y0 + (i - 1) / w;
                exp_v = (px >= 2) && (py >= 2);
                checks++;
                if (out_valid !== exp_v) begin
                    errors++;
                    $display("FAIL %s valid (%0d,%0d): got %b want %b", name, px, py, out_valid, exp_v);
                end
                if (exp_v) begin
                    checks++;
                    if (gauss_out !== exp_g) begin
                        errors++;
                        $display("FAIL %s gauss (%0d,%0d): got %h want %h", name, px, py, gauss_out, exp_g);
                    end
                    checks++;
                    if (gray_out !== exp_g) begin
                        errors++;
                        $display("FAIL %s gray (%0d,%0d): got %h want %h", name, px, py, gray_out, exp_g);
                    end
                    checks++;
                    if (out_x !== CW'(px - 1) || out_y !== CW'(py - 1)) begin
                        errors++;
                        $display("FAIL %s coord (%0d,%0d): got (%0d,%0d) want (%0d,%0d)",
                                 name, px, py, out_x, out_y, px - 1, py - 1);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        x_pixel = '0;
        y_pixel = '0;
        data    = '0;
        #2;
        checks++;
        if ({gauss_out, gray_out, out_x, out_y, out_valid} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h/%h/%0d/%0d/%b want all zero",
                     gauss_out, gray_out, out_x, out_y, out_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_uniform();
        stream_rect("uniform_888", 0, 7, 0, 3, 12'h888, 12'h888);
    endtask

    task automatic test_colour_weights();
        stream_rect("red", 0, 5, 0, 3, 12'hF00, 12'h444);
        stream_rect("green", 0, 5, 0, 3, 12'h0F0, 12'h888);
        stream_rect("blue", 0, 5, 0, 3, 12'h00F, 12'h111);
        stream_rect("white", 0, 5, 0, 3, 12'hFFF, 12'hFFF);
    endtask

    task automatic test_impulse();
        int total, px, py, cx, cy;
        bit tgt;
        logic [11:0] exp_g, exp_c;
        total = 7 * 5;
        for (int i = 0; i <= total; i++) begin
            px = 97 + i % 7;
            py = 48 + i / 7;
            if (i < total) feed(px, py, (px == 100 && py == 50) ? 12'hFFF : 12'h000);
            else idle();
            if (i > 0) begin
                cx = 97 + (i - 1) % 7 - 1;
                cy = 48 + (i - 1) / 7 - 1;
                tgt = 1'b1;
                if (cx == 100 && cy == 50) begin
                    exp_g = 12'h333; exp_c = 12'hFFF;
                end else if ((cx == 101 && cy == 50) || (cx == 100 && cy == 51)) begin
                    exp_g = 12'h111; exp_c = 12'h000;
                end else if (cx == 101 && cy == 51) begin
                    exp_g = 12'h000; exp_c = 12'h000;
                end else begin
                    tgt = 1'b0; exp_g = '0; exp_c = '0;
                end
                if (tgt) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_x !== CW'(cx) || out_y !== CW'(cy)) begin
                        errors++;
                        $display("FAIL impulse tag (%0d,%0d): got v=%b (%0d,%0d)", cx, cy, out_valid, out_x, out_y);
                    end
                    checks++;
                    if (gauss_out !== exp_g) begin
                        errors++;
                        $display("FAIL impulse gauss (%0d,%0d): got %h want %h", cx, cy, gauss_out, exp_g);
                    end
                    checks++;
                    if (gray_out !== exp_c) begin
                        errors++;
                        $display("FAIL impulse gray (%0d,%0d): got %h want %h", cx, cy, gray_out, exp_c);
                    end
                end
            end
        end
    endtask

    task automatic test_latency();
        idle();
        feed(5, 3, 12'h888);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got valid %b want 0", out_valid);
        end
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_x !== CW'(4) || out_y !== CW'(2)) begin
            errors++;
            $display("FAIL latency_coord: got v=%b (%0d,%0d) want v=1 (4,2)", out_valid, out_x, out_y);
        end
        feed(1, 3, 12'h888);
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL x_lt_2: got valid %b want 0", out_valid);
        end
        feed(5, 1, 12'h888);
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL y_lt_2: got valid %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        feed(10, 200, 12'h888);
        feed(11, 200, 12'h888);
        feed(12, 200, 12'h888);
        checks++;
        if (out_valid !== 1'b1 || out_x !== CW'(10) || out_y !== CW'(199)) begin
            errors++;
            $display("FAIL pre_reset: got v=%b (%0d,%0d) want v=1 (10,199)", out_valid, out_x, out_y);
        end
        // Assert reset between edges; outputs must clear without a clock edge.
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({gauss_out, gray_out, out_x, out_y, out_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h/%h/%0d/%0d/%b want all zero",
                     gauss_out, gray_out, out_x, out_y, out_valid);
        end
        // In-range pixel held across an edge while reset is asserted.
        feed(13, 200, 12'hFFF);
        checks++;
        if ({gauss_out, gray_out, out_x, out_y, out_valid} !== '0) begin
            errors++;
            $display("FAIL reset_wins: got %h/%h/%0d/%0d/%b want all zero",
                     gauss_out, gray_out, out_x, out_y, out_valid);
        end
        reset = 1'b0;
        stream_rect("restart", 0, 5, 0, 2, 12'h0F0, 12'h888);
    endtask

    task automatic test_out_of_range();
        stream_rect("oor_pre", 0, 5, 0, 2, 12'hFFF, 12'hFFF);
        for (int x = 0; x < 4; x++) feed(x, 3, 12'hFFF);
        feed(700, 3, 12'h000);
        checks++;
        if (out_valid !== 1'b1 || out_x !== CW'(2)) begin
            errors++;
            $display("FAIL oor_before: got v=%b x=%0d want v=1 x=2", out_valid, out_x);
        end
        feed(4, 3, 12'hFFF);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL oor_valid: got %b want 0", out_valid);
        end
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_x !== CW'(3) || out_y !== CW'(2)) begin
            errors++;
            $display("FAIL oor_after_coord: got v=%b (%0d,%0d) want v=1 (3,2)", out_valid, out_x, out_y);
        end
        checks++;
        if (gauss_out !== 12'hFFF || gray_out !== 12'hFFF) begin
            errors++;
            $display("FAIL oor_window: got gauss %h gray %h want FFF FFF", gauss_out, gray_out);
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_colour_weights();
        test_impulse();
        test_latency();
        test_reset_mid_frame();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
